// File: rtl/extn_pkg.sv
// Shared types and constants for the immediate extension stage.
package extn_pkg;

    typedef enum logic [1:0] {
        EXT_SIGN   = 2'b00,
        EXT_ZERO   = 2'b01,
        EXT_UPPER  = 2'b10,
        EXT_BRANCH = 2'b11
    } extn_mode_t;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b10
    } extn_state_t;

    localparam int unsigned BRANCH_SHIFT = 2;

endpackage

// File: rtl/extn_core.sv
// Combinational immediate widening by mode.
// EXTN_UPPER_EN enables UPPER/BRANCH modes; otherwise both decode as SIGN.
module extn_core
    import extn_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic [IN_W-1:0]  data_in,
    input  extn_mode_t       mode,
    output logic [OUT_W-1:0] data_out
);

    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] zext;

    always_comb begin
        sext = {{(OUT_W-IN_W){data_in[IN_W-1]}}, data_in};
        zext = {{(OUT_W-IN_W){1'b0}}, data_in};
    end

`ifdef EXTN_UPPER_EN
    always_comb begin
        data_out = sext;
        case (mode)
            EXT_SIGN:   data_out = sext;
            EXT_ZERO:   data_out = zext;
            EXT_UPPER:  data_out = {data_in, {(OUT_W-IN_W){1'b0}}};
            EXT_BRANCH: data_out = sext << BRANCH_SHIFT;
            default:    data_out = sext;
        endcase
    end
`else
    always_comb begin
        data_out = (mode == EXT_ZERO) ? zext : sext;
    end
`endif

endmodule

// File: rtl/extn_stage.sv
// Registered immediate extension stage with a two-entry skid buffer.
// Optional macro EXTN_UPPER_EN (see extn_core) enables UPPER/BRANCH modes.
module extn_stage
    import extn_pkg::*;
#(
    parameter int unsigned IN_W  = 16,
    parameter int unsigned OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [IN_W-1:0]  data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] data_out
);

    extn_state_t      state_q;
    logic [OUT_W-1:0] main_q;
    logic [OUT_W-1:0] skid_q;
    logic [OUT_W-1:0] ext;
    logic             accept;
    logic             retire;

    extn_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_core (
        .data_in  (data_in),
        .mode     (extn_mode_t'(in_mode)),
        .data_out (ext)
    );

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign data_out  = main_q;
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else if (flush) begin
            state_q <= EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q  <= ext;
                        state_q <= ONE;
                    end
                end
                ONE: begin
                    // Simultaneous accept+retire bypasses skid to keep one-cycle latency.
                    if (accept && retire) begin
                        main_q <= ext;
                    end else if (accept) begin
                        skid_q  <= ext;
                        state_q <= TWO;
                    end else if (retire) begin
                        state_q <= EMPTY;
                    end
                end
                TWO: begin
                    if (retire) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_extn_stage.sv
// Scoreboard bench for extn_stage; expectations follow the EXTN_UPPER_EN setting.
`timescale 1ns/1ps
module tb_extn_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_mode;
    logic [15:0] data_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;

    int unsigned checks  = 0;
    int unsigned fails   = 0;
    int unsigned retired = 0;
    logic [31:0] expq[$];

    extn_stage #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mode   (in_mode),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // A retirement happens at the coming posedge; inputs only change at posedge+1.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            retired++;
            checks++;
            if (expq.size() == 0) begin
                fails++;
                $display("FAIL sb_unexpected: got %h expected no output", data_out);
            end else begin
                logic [31:0] e;
                e = expq.pop_front();
                if (data_out !== e) begin
                    fails++;
                    $display("FAIL sb_data: got %h expected %h", data_out, e);
                end
            end
        end
    end

    task automatic cyc(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push(input logic [15:0] d, input logic [1:0] m, input logic [31:0] e);
        int unsigned n;
        n = 0;
        in_valid = 1'b1;
        data_in  = d;
        in_mode  = m;
        while (!in_ready && n < 20) begin
            cyc(1);
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL push_timeout: got in_ready=0 expected 1 within 20 cycles");
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        expq.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int unsigned n;
        n = 0;
        while (expq.size() != 0 && n < 50) begin
            cyc(1);
            n++;
        end
        check(name, expq.size(), 32'd0);
    endtask

    typedef struct {
        logic [15:0] d;
        logic [1:0]  m;
        logic [31:0] e_en;
        logic [31:0] e_dis;
    } vec_t;

    vec_t vecs[8];
    logic [31:0] exp_v;
    int unsigned r0;

    initial begin
        vecs[0] = '{16'h8001, 2'b00, 32'hFFFF8001, 32'hFFFF8001};
        vecs[1] = '{16'h8001, 2'b01, 32'h00008001, 32'h00008001};
        vecs[2] = '{16'h1234, 2'b10, 32'h12340000, 32'h00001234};
        vecs[3] = '{16'hFFFF, 2'b11, 32'hFFFFFFFC, 32'hFFFFFFFF};
        vecs[4] = '{16'h8001, 2'b10, 32'h80010000, 32'hFFFF8001};
        vecs[5] = '{16'h7FFF, 2'b00, 32'h00007FFF, 32'h00007FFF};
        vecs[6] = '{16'h4000, 2'b11, 32'h00010000, 32'h00004000};
        vecs[7] = '{16'h8000, 2'b11, 32'hFFFE0000, 32'hFFFF8000};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_mode = 2'b00;
        data_in = '0; out_ready = 1'b1;
        cyc(2);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_data_out", data_out, 32'd0);
        rst = 1'b0;
        cyc(1);

        // Mode decode, one cycle latency from EMPTY
        foreach (vecs[i]) begin
`ifdef EXTN_UPPER_EN
            exp_v = vecs[i].e_en;
`else
            exp_v = vecs[i].e_dis;
`endif
            push(vecs[i].d, vecs[i].m, exp_v);
            check("latency_out_valid", {31'd0, out_valid}, 32'd1);
            cyc(1);
        end
        drain("modes_drain");

        // Back-pressure
        out_ready = 1'b0;
        push(16'h0001, 2'b00, 32'h00000001);
        push(16'h0002, 2'b00, 32'h00000002);
        check("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_data", data_out, 32'h00000001);
        cyc(3);
        check("bp_hold_data", data_out, 32'h00000001);
        check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        cyc(1);
        check("bp_in_ready_back", {31'd0, in_ready}, 32'd1);
        check("bp_second", data_out, 32'h00000002);
        drain("bp_drain");
        cyc(1);

        // Streaming: 8 entries, no bubbles
        r0 = retired;
        for (int unsigned i = 0; i < 8; i++) begin
            push(16'h0100 + 16'(i), 2'b01, 32'h00000100 + i);
        end
        cyc(1);
        check("stream_count", retired - r0, 32'd8);
        drain("stream_drain");

        // Flush in TWO with a third entry offered
        out_ready = 1'b0;
        push(16'h0011, 2'b00, 32'h00000011);
        push(16'h0022, 2'b00, 32'h00000022);
        check("pre_flush_full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1; in_valid = 1'b1; data_in = 16'h0033; in_mode = 2'b00;
        @(posedge clk);
        expq.delete();
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush2_out_valid", {31'd0, out_valid}, 32'd0);
        check("flush2_in_ready", {31'd0, in_ready}, 32'd1);
        check("flush2_data_kept", data_out, 32'h00000011);
        out_ready = 1'b1;
        cyc(4);

        // Flush in ONE discards the same-edge acceptance
        out_ready = 1'b0;
        push(16'h0044, 2'b00, 32'h00000044);
        flush = 1'b1; in_valid = 1'b1; data_in = 16'h0045; in_mode = 2'b01;
        @(posedge clk);
        expq.delete();
        #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush1_out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        cyc(4);

        // Reset while in TWO
        out_ready = 1'b0;
        push(16'h0066, 2'b00, 32'h00000066);
        push(16'h0077, 2'b00, 32'h00000077);
        rst = 1'b1;
        @(posedge clk);
        expq.delete();
        #1;
        rst = 1'b0;
        check("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst2_data_out", data_out, 32'd0);
        out_ready = 1'b1;
        r0 = retired;
        push(16'hF055, 2'b01, 32'h0000F055);
        cyc(4);
        check("rst2_alone", retired - r0, 32'd1);
        drain("final_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish before 200us");
        $fatal(1, "timeout");
    end

endmodule
